// File: rtl/uart_rx_fifo_ctrl_if.sv
// Receive-side bundle between uart_rx, the FIFO controller and its consumer/host.
// master = controller (drives the stream and status), slave = surrounding logic.
interface uart_rx_fifo_ctrl_if #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0]     rx_data;
    logic                     rx_data_ready;
    logic                     rx_parity_err;
    logic                     rx_frame_err;
    logic                     rx_enable;
    logic                     flush;
    logic                     clear_status;

    logic                     m_valid;
    logic [DATA_BITS-1:0]     m_data;
    logic                     m_parity_err;
    logic                     m_frame_err;
    logic                     m_ready;

    logic [CW-1:0]            fifo_count;
    logic                     overrun;
    logic [ERR_CNT_WIDTH-1:0] parity_err_count;
    logic [ERR_CNT_WIDTH-1:0] frame_err_count;

    modport master (
        input  rx_data, rx_data_ready, rx_parity_err, rx_frame_err, rx_enable,
        input  flush, clear_status, m_ready,
        output m_valid, m_data, m_parity_err, m_frame_err,
        output fifo_count, overrun, parity_err_count, frame_err_count
    );

    modport slave (
        output rx_data, rx_data_ready, rx_parity_err, rx_frame_err, rx_enable,
        output flush, clear_status, m_ready,
        input  m_valid, m_data, m_parity_err, m_frame_err,
        input  fifo_count, overrun, parity_err_count, frame_err_count
    );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// Edge-detects uart_rx data_ready, pushes {frame_err, parity_err, data} into a show-ahead FIFO
// (1-cycle empty-to-valid), streams it out valid/ready and keeps sticky overrun + saturating error counts.
module uart_rx_fifo_ctrl #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_rx_fifo_ctrl_if.master      bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "uart_rx_fifo_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic                     ready_q, ready_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     overrun_q, overrun_d;
    logic [ERR_CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] frm_cnt_q, frm_cnt_d;
    logic [EW-1:0]            mem_q [FIFO_DEPTH];
    logic [EW-1:0]            mem_d [FIFO_DEPTH];

    logic frame_evt;
    logic full;
    logic valid;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic ovr_set;
    logic [EW-1:0] head;

    always_comb begin
        ready_d   = bus.rx_data_ready;
        frame_evt = bus.rx_data_ready & ~ready_q & bus.rx_enable;
        full      = (count_q == CW'(FIFO_DEPTH));
        valid     = (count_q != '0);
        pop_req   = valid & bus.m_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
        do_push   = frame_evt & (~full | pop_req) & ~bus.flush;
        do_pop    = pop_req & ~bus.flush;
        ovr_set   = frame_evt & full & ~pop_req & ~bus.flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = {bus.rx_frame_err, bus.rx_parity_err, bus.rx_data};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Clear wins over held status, but an event in the clear cycle still leaves its own mark.
    always_comb begin
        overrun_d = bus.clear_status ? ovr_set : (overrun_q | ovr_set);

        par_cnt_d = bus.clear_status ? '0 : par_cnt_q;
        if (frame_evt && bus.rx_parity_err && par_cnt_d != '1) begin
            par_cnt_d = par_cnt_d + ERR_CNT_WIDTH'(1);
        end

        frm_cnt_d = bus.clear_status ? '0 : frm_cnt_q;
        if (frame_evt && bus.rx_frame_err && frm_cnt_d != '1) begin
            frm_cnt_d = frm_cnt_d + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
        end else begin
            ready_q   <= ready_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            par_cnt_q <= par_cnt_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

    // Storage carries no reset; contents are only observable once count says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head                 = mem_q[rd_ptr_q];
    assign bus.m_valid          = valid;
    assign bus.m_data           = head[DATA_BITS-1:0];
    assign bus.m_parity_err     = head[DATA_BITS];
    assign bus.m_frame_err      = head[DATA_BITS+1];
    assign bus.fifo_count       = count_q;
    assign bus.overrun          = overrun_q;
    assign bus.parity_err_count = par_cnt_q;
    assign bus.frame_err_count  = frm_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl at DATA_BITS=8, FIFO_DEPTH=8, ERR_CNT_WIDTH=8.
module tb_uart_rx_fifo_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    uart_rx_fifo_ctrl_if #(.DATA_BITS(8), .FIFO_DEPTH(8), .ERR_CNT_WIDTH(8)) bus ();

    uart_rx_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(8), .ERR_CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe, input int hold);
        bus.rx_data       = d;
        bus.rx_parity_err = pe;
        bus.rx_frame_err  = fe;
        bus.rx_data_ready = 1'b1;
        repeat (hold) step();
        bus.rx_data_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.rx_data       = '0;
        bus.rx_data_ready = 1'b1;
        bus.rx_parity_err = 1'b0;
        bus.rx_frame_err  = 1'b0;
        bus.rx_enable     = 1'b1;
        bus.flush         = 1'b0;
        bus.clear_status  = 1'b0;
        bus.m_ready       = 1'b0;
        repeat (3) step();
        check("rst_valid", bus.m_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_pcnt", bus.parity_err_count, 0);
        check("rst_fcnt", bus.frame_err_count, 0);

        // data_ready already high at release must not be captured
        reset = 1'b0;
        repeat (3) step();
        check("hi_at_release_count", bus.fifo_count, 0);
        check("hi_at_release_valid", bus.m_valid, 0);
        bus.rx_data_ready = 1'b0;
        step();
        step();

        send_frame(8'h41, 1'b0, 1'b0, 16);
        send_frame(8'h42, 1'b0, 1'b0, 16);
        send_frame(8'h43, 1'b0, 1'b0, 16);
        check("three_count", bus.fifo_count, 3);
        check("three_valid", bus.m_valid, 1);
        check("three_head", bus.m_data, 8'h41);
        bus.m_ready = 1'b1;
        check("pop0", bus.m_data, 8'h41);
        step();
        check("pop1", bus.m_data, 8'h42);
        step();
        check("pop2", bus.m_data, 8'h43);
        step();
        check("drained_valid", bus.m_valid, 0);
        check("drained_count", bus.fifo_count, 0);
        bus.m_ready = 1'b0;

        // Push latency: count becomes 1 right after the event edge.
        bus.rx_data       = 8'h5a;
        bus.rx_data_ready = 1'b1;
        check("lat_before", bus.m_valid, 0);
        step();
        check("lat_valid", bus.m_valid, 1);
        check("lat_data", bus.m_data, 8'h5a);
        bus.rx_data_ready = 1'b0;
        bus.m_ready       = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("lat_popped", bus.fifo_count, 0);
        step();

        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0, 2);
        check("ovr_count", bus.fifo_count, 8);
        check("ovr_flag", bus.overrun, 1);
        check("ovr_head", bus.m_data, 8'h00);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovr_drain", bus.m_data, 32'(i));
            step();
        end
        check("ovr_9th_absent", bus.m_valid, 0);
        bus.m_ready = 1'b0;
        check("ovr_sticky", bus.overrun, 1);
        bus.clear_status = 1'b1;
        step();
        bus.clear_status = 1'b0;
        check("ovr_cleared", bus.overrun, 0);

        // Full FIFO with a pop in the event cycle: frame stored, no overrun.
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 2);
        check("full_count", bus.fifo_count, 8);
        bus.rx_data       = 8'h18;
        bus.rx_data_ready = 1'b1;
        bus.m_ready       = 1'b1;
        step();
        bus.m_ready       = 1'b0;
        bus.rx_data_ready = 1'b0;
        check("fullpop_overrun", bus.overrun, 0);
        check("fullpop_count", bus.fifo_count, 8);
        check("fullpop_head", bus.m_data, 8'h11);
        step();
        step();
        bus.m_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check("fullpop_drain", bus.m_data, 32'h10 + 32'(i));
            step();
        end
        check("fullpop_empty", bus.m_valid, 0);
        bus.m_ready = 1'b0;

        for (int i = 0; i < 300; i++) send_frame(8'h77, 1'b1, (i < 2), 2);
        check("pcnt_sat", bus.parity_err_count, 255);
        check("fcnt_two", bus.frame_err_count, 2);
        check("err_overrun", bus.overrun, 1);
        bus.rx_parity_err = 1'b1;
        bus.rx_frame_err  = 1'b0;
        bus.rx_data_ready = 1'b1;
        bus.clear_status  = 1'b1;
        step();
        bus.clear_status  = 1'b0;
        bus.rx_data_ready = 1'b0;
        check("clr_evt_pcnt", bus.parity_err_count, 1);
        check("clr_evt_fcnt", bus.frame_err_count, 0);
        check("clr_evt_overrun", bus.overrun, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_full", bus.fifo_count, 0);
        bus.clear_status = 1'b1;
        step();
        bus.clear_status = 1'b0;
        check("status_clear", bus.parity_err_count, 0);

        for (int i = 0; i < 5; i++) send_frame(8'h50 + 8'(i), 1'b0, 1'b0, 2);
        check("five_count", bus.fifo_count, 5);
        bus.rx_data       = 8'h55;
        bus.rx_frame_err  = 1'b1;
        bus.rx_data_ready = 1'b1;
        bus.flush         = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_evt_count", bus.fifo_count, 0);
        check("flush_evt_valid", bus.m_valid, 0);
        check("flush_evt_overrun", bus.overrun, 0);
        check("flush_evt_fcnt", bus.frame_err_count, 1);
        bus.rx_data_ready = 1'b0;
        step();
        step();
        check("flush_discarded", bus.fifo_count, 0);

        bus.rx_enable = 1'b0;
        send_frame(8'h66, 1'b0, 1'b1, 4);
        check("dis_count", bus.fifo_count, 0);
        check("dis_fcnt", bus.frame_err_count, 1);
        bus.rx_enable = 1'b1;

        // Asynchronous reset mid-operation clears state without waiting for an edge.
        send_frame(8'h99, 1'b1, 1'b0, 2);
        check("pre_arst_count", bus.fifo_count, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_count", bus.fifo_count, 0);
        check("arst_valid", bus.m_valid, 0);
        check("arst_pcnt", bus.parity_err_count, 0);
        step();
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
